// File: rtl/uio_bus_arbiter_if.sv
// Handshake and pad-bus bundle between the uio_bus_arbiter and the user logic / uio pads.
// The arbiter connects through the slave modport; the requester side uses master.
`timescale 1ns/1ps
interface uio_bus_arbiter_if #(
    parameter int N_REQ = 4
);
    localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]   req;
    logic [N_REQ-1:0]   rd_wr;
    logic [8*N_REQ-1:0] wdata;
    logic [N_REQ-1:0]   done;
    logic [N_REQ-1:0]   gnt;
    logic [OW-1:0]      owner;
    logic               busy;
    logic [7:0]         rdata;
    logic               rvalid;
    logic               timeout_err;
    logic [7:0]         uio_in;
    logic [7:0]         uio_out;
    logic [7:0]         uio_oe;

    modport master (
        output req, rd_wr, wdata, done, uio_in,
        input  gnt, owner, busy, rdata, rvalid, timeout_err, uio_out, uio_oe
    );

    modport slave (
        input  req, rd_wr, wdata, done, uio_in,
        output gnt, owner, busy, rdata, rvalid, timeout_err, uio_out, uio_oe
    );
endinterface

// File: rtl/uio_bus_arbiter.sv
// Round-robin owner of the 8-bit uio pad bus: one requester at a time drives or samples it,
// with a high-Z turnaround between tenures and a hold timeout that forces release.
`timescale 1ns/1ps
module uio_bus_arbiter #(
    parameter int N_REQ    = 4,
    parameter int MAX_HOLD = 16,
    parameter int TURN     = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    uio_bus_arbiter_if.slave      bus
);
    localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_TURN
    } state_t;

    state_t        state;
    logic [7:0]    hold_cnt;
    logic [1:0]    turn_cnt;
    logic          mode_wr;

    logic          pick_valid;
    logic [OW-1:0] pick_idx;
    logic [OW-1:0] cand_idx;
    int            cand;
    logic          owner_done;
    logic          timed_out;

    // Walk the ring downward so the requester nearest after the last owner is written last and wins.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        cand_idx   = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            cand = int'(bus.owner) + k;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            cand_idx = OW'(cand);
            if (bus.req[cand_idx]) begin
                pick_valid = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    // A dropped request ends the tenure exactly like an explicit done.
    assign owner_done = bus.done[bus.owner] || !bus.req[bus.owner];
    assign timed_out  = (hold_cnt == 8'(MAX_HOLD));
    assign bus.busy   = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            bus.gnt         <= '0;
            bus.owner       <= OW'(N_REQ - 1);
            bus.rdata       <= '0;
            bus.rvalid      <= 1'b0;
            bus.timeout_err <= 1'b0;
            bus.uio_out     <= '0;
            bus.uio_oe      <= '0;
            hold_cnt        <= '0;
            turn_cnt        <= '0;
            mode_wr         <= 1'b0;
        end else begin
            bus.timeout_err <= 1'b0;
            bus.rvalid      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (ena && pick_valid) begin
                        state       <= S_GRANT;
                        bus.gnt     <= ONE_HOT0 << pick_idx;
                        bus.owner   <= pick_idx;
                        mode_wr     <= bus.rd_wr[pick_idx];
                        hold_cnt    <= 8'd1;
                        bus.uio_oe  <= {8{bus.rd_wr[pick_idx]}};
                        bus.uio_out <= bus.rd_wr[pick_idx] ? bus.wdata[{pick_idx, 3'b000} +: 8] : 8'h00;
                    end
                end
                S_GRANT: begin
                    if (!mode_wr) begin
                        bus.rdata  <= bus.uio_in;
                        bus.rvalid <= 1'b1;
                    end
                    if (owner_done || timed_out || !ena) begin
                        state           <= S_TURN;
                        bus.gnt         <= '0;
                        bus.uio_oe      <= '0;
                        bus.uio_out     <= '0;
                        hold_cnt        <= '0;
                        turn_cnt        <= 2'd1;
                        bus.timeout_err <= timed_out && !owner_done;
                    end else begin
                        hold_cnt <= hold_cnt + 8'd1;
                        if (mode_wr) begin
                            bus.uio_out <= bus.wdata[{bus.owner, 3'b000} +: 8];
                        end
                    end
                end
                S_TURN: begin
                    if (turn_cnt == 2'(TURN)) begin
                        state <= S_IDLE;
                    end else begin
                        turn_cnt <= turn_cnt + 2'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uio_bus_arbiter.sv
// Directed bench for uio_bus_arbiter: write, round-robin, read, timeout, enable and async reset.
`timescale 1ns/1ps
module tb_uio_bus_arbiter;
    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       ena   = 1'b0;
    logic [7:0] wd [4];
    logic [3:0] rr_exp;
    int         checks = 0;
    int         errors = 0;

    uio_bus_arbiter_if #(.N_REQ(4)) bus ();

    uio_bus_arbiter #(
        .N_REQ   (4),
        .MAX_HOLD(16),
        .TURN    (1)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .ena  (ena),
        .bus  (bus.slave)
    );

    assign bus.wdata = {wd[3], wd[2], wd[1], wd[0]};

    always #5 clk = ~clk;

    task automatic nextCycle();
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [3:0] r, input logic [3:0] rw, input logic [3:0] d);
        bus.req   = r;
        bus.rd_wr = rw;
        bus.done  = d;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkBus(input string tag, input logic [3:0] g, input logic [7:0] oe,
                            input logic [7:0] dout, input logic b);
        checkOutput({tag, "_gnt"}, 32'(bus.gnt), 32'(g));
        checkOutput({tag, "_oe"}, 32'(bus.uio_oe), 32'(oe));
        checkOutput({tag, "_out"}, 32'(bus.uio_out), 32'(dout));
        checkOutput({tag, "_busy"}, 32'(bus.busy), 32'(b));
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        ena   = 1'b0;
        applyStimulus(4'b0000, 4'b0000, 4'b0000);
        bus.uio_in = 8'h00;
        for (int i = 0; i < 4; i++) wd[i] = 8'h00;
        nextCycle();
        nextCycle();
        rst_n = 1'b1;
        nextCycle();
    endtask

    initial begin
        #1;
        doReset();
        checkBus("rst", 4'b0000, 8'h00, 8'h00, 1'b0);
        checkOutput("rst_owner", 32'(bus.owner), 32'd3);
        checkOutput("rst_rvalid", 32'(bus.rvalid), 32'd0);
        checkOutput("rst_rdata", 32'(bus.rdata), 32'd0);
        checkOutput("rst_timeout", 32'(bus.timeout_err), 32'd0);

        // Single write tenure from requester 0, then the turnaround gap.
        ena   = 1'b1;
        wd[0] = 8'hA5;
        applyStimulus(4'b0001, 4'b0001, 4'b0000);
        nextCycle();
        checkBus("w_grant", 4'b0001, 8'hFF, 8'hA5, 1'b1);
        checkOutput("w_owner", 32'(bus.owner), 32'd0);
        wd[0] = 8'h3C;
        nextCycle();
        checkBus("w_update", 4'b0001, 8'hFF, 8'h3C, 1'b1);
        applyStimulus(4'b0001, 4'b0001, 4'b0001);
        nextCycle();
        checkBus("w_done", 4'b0000, 8'h00, 8'h00, 1'b1);
        checkOutput("w_done_to", 32'(bus.timeout_err), 32'd0);
        applyStimulus(4'b0001, 4'b0001, 4'b0000);
        nextCycle();
        checkBus("w_gap", 4'b0000, 8'h00, 8'h00, 1'b0);
        nextCycle();
        checkBus("w_regrant", 4'b0001, 8'hFF, 8'h3C, 1'b1);
        applyStimulus(4'b0000, 4'b0000, 4'b0000);
        nextCycle();
        checkBus("w_reqdrop", 4'b0000, 8'h00, 8'h00, 1'b1);
        checkOutput("w_reqdrop_to", 32'(bus.timeout_err), 32'd0);
        nextCycle();

        // Round robin from reset with all four requesting; non-owner done is ignored.
        doReset();
        ena = 1'b1;
        applyStimulus(4'b1111, 4'b1111, 4'b0000);
        for (int i = 0; i < 5; i++) begin
            rr_exp = 4'b0001 << (i % 4);
            nextCycle();
            checkOutput("rr_grant", 32'(bus.gnt), 32'(rr_exp));
            checkOutput("rr_owner", 32'(bus.owner), 32'(i % 4));
            applyStimulus(4'b1111, 4'b1111, ~rr_exp);
            nextCycle();
            checkOutput("rr_hold", 32'(bus.gnt), 32'(rr_exp));
            applyStimulus(4'b1111, 4'b1111, rr_exp);
            nextCycle();
            applyStimulus(4'b1111, 4'b1111, 4'b0000);
            checkOutput("rr_turn", 32'(bus.gnt), 32'd0);
            nextCycle();
            checkOutput("rr_idle", 32'(bus.gnt), 32'd0);
        end
        applyStimulus(4'b0000, 4'b0000, 4'b0000);

        // Read tenure by requester 2 sampling the pads.
        bus.uio_in = 8'h11;
        applyStimulus(4'b0100, 4'b0000, 4'b0000);
        nextCycle();
        checkBus("r_grant", 4'b0100, 8'h00, 8'h00, 1'b1);
        checkOutput("r_owner", 32'(bus.owner), 32'd2);
        checkOutput("r_rvalid0", 32'(bus.rvalid), 32'd0);
        nextCycle();
        checkOutput("r_data11", 32'(bus.rdata), 32'h11);
        checkOutput("r_rvalid1", 32'(bus.rvalid), 32'd1);
        bus.uio_in = 8'h22;
        nextCycle();
        checkOutput("r_data22", 32'(bus.rdata), 32'h22);
        bus.uio_in = 8'h33;
        applyStimulus(4'b0100, 4'b0000, 4'b0100);
        nextCycle();
        checkOutput("r_rel_gnt", 32'(bus.gnt), 32'd0);
        checkOutput("r_data33", 32'(bus.rdata), 32'h33);
        checkOutput("r_rvalid_tail", 32'(bus.rvalid), 32'd1);
        applyStimulus(4'b0000, 4'b0000, 4'b0000);
        bus.uio_in = 8'h99;
        nextCycle();
        checkOutput("r_rvalid_off", 32'(bus.rvalid), 32'd0);
        checkOutput("r_data_hold", 32'(bus.rdata), 32'h33);

        // Hold timeout on requester 1, then done on the last allowed cycle.
        wd[1] = 8'h5A;
        applyStimulus(4'b0010, 4'b0010, 4'b0000);
        for (int i = 1; i <= 16; i++) begin
            nextCycle();
            checkOutput("to_hold", 32'(bus.gnt), 32'b0010);
        end
        nextCycle();
        checkBus("to_rel", 4'b0000, 8'h00, 8'h00, 1'b1);
        checkOutput("to_pulse", 32'(bus.timeout_err), 32'd1);
        applyStimulus(4'b0000, 4'b0000, 4'b0000);
        nextCycle();
        checkOutput("to_pulse_end", 32'(bus.timeout_err), 32'd0);
        applyStimulus(4'b0010, 4'b0010, 4'b0000);
        for (int i = 1; i <= 16; i++) begin
            nextCycle();
            checkOutput("td_hold", 32'(bus.gnt), 32'b0010);
            if (i == 16) applyStimulus(4'b0010, 4'b0010, 4'b0010);
        end
        nextCycle();
        checkOutput("td_gnt", 32'(bus.gnt), 32'd0);
        checkOutput("td_no_pulse", 32'(bus.timeout_err), 32'd0);
        applyStimulus(4'b0000, 4'b0000, 4'b0000);
        nextCycle();

        // Enable drop forces release and blocks new grants until it returns.
        wd[0] = 8'h77;
        applyStimulus(4'b0001, 4'b0001, 4'b0000);
        nextCycle();
        checkBus("en_grant", 4'b0001, 8'hFF, 8'h77, 1'b1);
        ena = 1'b0;
        nextCycle();
        checkBus("en_rel", 4'b0000, 8'h00, 8'h00, 1'b1);
        nextCycle();
        checkBus("en_idle", 4'b0000, 8'h00, 8'h00, 1'b0);
        nextCycle();
        checkBus("en_block", 4'b0000, 8'h00, 8'h00, 1'b0);
        ena = 1'b1;
        nextCycle();
        checkBus("en_resume", 4'b0001, 8'hFF, 8'h77, 1'b1);

        // Asynchronous reset in the middle of a write tenure.
        nextCycle();
        #2 rst_n = 1'b0;
        #1;
        checkBus("ar", 4'b0000, 8'h00, 8'h00, 1'b0);
        checkOutput("ar_owner", 32'(bus.owner), 32'd3);
        nextCycle();
        rst_n = 1'b1;
        wd[3] = 8'hEE;
        applyStimulus(4'b1001, 4'b1001, 4'b0000);
        nextCycle();
        checkOutput("ar_prio_gnt", 32'(bus.gnt), 32'b0001);
        checkOutput("ar_prio_owner", 32'(bus.owner), 32'd0);
        checkOutput("ar_prio_out", 32'(bus.uio_out), 32'h77);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
